// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: fetch FSM encoding, reset constants and RV32I field positions
package instr_fetch_pkg;
  typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} state_e;
  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_W   = 7;
  localparam int RD_LSB     = 7;
  localparam int RD_W       = 5;
  localparam int FUNCT3_LSB = 12;
  localparam int FUNCT3_W   = 3;
  localparam int RS1_LSB    = 15;
  localparam int RS1_W      = 5;
  localparam int RS2_LSB    = 20;
  localparam int RS2_W      = 5;
  localparam int FUNCT7_LSB = 25;
  localparam int FUNCT7_W   = 7;
endpackage

// File: rtl/instr_fetch.sv
// instr_fetch: PC register plus single-outstanding instruction fetch into IR
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IR_Write,
  input  logic        PC_Write,
  input  logic        PC_Sel,
  input  logic [31:0] PC_New,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] PC,
  output logic [31:0] PC_Old,
  output logic [31:0] IR,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic        fetch_busy,
  output logic        misalign
);
  state_e      state_q;
  logic        req_q, misalign_q;
  logic [31:0] addr_q, pc_q, pc_old_q, ir_q, pc_d;
  assign pc_d = PC_Sel ? {PC_New[31:2], 2'b00} : pc_q + 32'd4;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
      pc_q       <= RESET_PC;
      pc_old_q   <= RESET_PC;
      ir_q       <= NOP_INSTR;
      misalign_q <= 1'b0;
    end else begin
      if (PC_Write) begin
        pc_q <= pc_d;
        if (PC_Sel && |PC_New[1:0]) misalign_q <= 1'b1;
      end
      // fetch address is the PC before any same-edge update
      if (state_q == IDLE && IR_Write) begin
        state_q <= FETCH;
        req_q   <= 1'b1;
        addr_q  <= pc_q;
      end else if (state_q == FETCH && imem_ack) begin
        state_q  <= IDLE;
        req_q    <= 1'b0;
        ir_q     <= imem_rdata;
        pc_old_q <= addr_q;
      end
    end
  end
  assign imem_req   = req_q;
  assign imem_addr  = addr_q;
  assign PC         = pc_q;
  assign PC_Old     = pc_old_q;
  assign IR         = ir_q;
  assign misalign   = misalign_q;
  assign fetch_busy = (state_q == FETCH);
  assign opcode     = ir_q[OPCODE_LSB +: OPCODE_W];
  assign funct3     = ir_q[FUNCT3_LSB +: FUNCT3_W];
  assign funct7     = ir_q[FUNCT7_LSB +: FUNCT7_W];
  assign rd         = ir_q[RD_LSB +: RD_W];
  assign rs1        = ir_q[RS1_LSB +: RS1_W];
  assign rs2        = ir_q[RS2_LSB +: RS2_W];
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed and random checks of instr_fetch against a transaction-level model
module tb_instr_fetch;
  logic        clk = 1'b0;
  logic        rst = 1'b1, IR_Write = 1'b0, PC_Write = 1'b0, PC_Sel = 1'b0, imem_ack = 1'b0;
  logic [31:0] PC_New = '0, imem_rdata = '0;
  logic        imem_req, fetch_busy, misalign;
  logic [31:0] imem_addr, PC, PC_Old, IR;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  int n_cmp = 0, n_err = 0;
  bit          m_busy, m_mis;
  logic [31:0] m_addr, m_pc, m_old, m_ir;
  instr_fetch dut (
    .clk(clk), .rst(rst), .IR_Write(IR_Write), .PC_Write(PC_Write), .PC_Sel(PC_Sel),
    .PC_New(PC_New), .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ack(imem_ack), .PC(PC), .PC_Old(PC_Old), .IR(IR), .opcode(opcode), .funct3(funct3),
    .funct7(funct7), .rd(rd), .rs1(rs1), .rs2(rs2), .fetch_busy(fetch_busy), .misalign(misalign)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic check_all();
    chk("imem_req", imem_req, m_busy);
    chk("fetch_busy", fetch_busy, m_busy);
    chk("imem_addr", imem_addr, m_addr);
    chk("PC", PC, m_pc);
    chk("PC_Old", PC_Old, m_old);
    chk("IR", IR, m_ir);
    chk("misalign", misalign, m_mis);
    chk("opcode", opcode, m_ir & 32'h7f);
    chk("rd", rd, (m_ir >> 7) & 32'h1f);
    chk("funct3", funct3, (m_ir >> 12) & 32'h7);
    chk("rs1", rs1, (m_ir >> 15) & 32'h1f);
    chk("rs2", rs2, (m_ir >> 20) & 32'h1f);
    chk("funct7", funct7, m_ir >> 25);
  endtask
  task automatic step(input logic r, iw, pw, ps, input logic [31:0] pn, input logic ak,
                      input logic [31:0] rdat);
    @(negedge clk);
    rst = r; IR_Write = iw; PC_Write = pw; PC_Sel = ps; PC_New = pn; imem_ack = ak; imem_rdata = rdat;
    if (r) begin
      m_busy = 0; m_mis = 0; m_addr = 0; m_pc = 0; m_old = 0; m_ir = 32'h13;
    end else begin
      if (!m_busy && iw) begin
        m_busy = 1; m_addr = m_pc;
      end else if (m_busy && ak) begin
        m_busy = 0; m_ir = rdat; m_old = m_addr;
      end
      if (pw) begin
        m_pc = ps ? pn - (pn % 4) : m_pc + 4;
        if (ps && pn % 4 != 0) m_mis = 1;
      end
    end
    @(posedge clk); #1;
    check_all();
  endtask
  initial begin
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("rst_IR", IR, 32'h13);
    // fetch with PC increment, zero-wait ack
    step(0, 1, 1, 0, 0, 0, 0);
    chk("t34_addr", imem_addr, 0);
    chk("t34_pc", PC, 4);
    step(0, 0, 0, 0, 0, 1, 32'h0050_0093);
    chk("t34_ir", IR, 32'h0050_0093);
    chk("t34_old", PC_Old, 0);
    chk("t34_rd", rd, 1);
    chk("t34_op", opcode, 7'h13);
    // delayed ack with repeated IR_Write during the fetch
    step(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, i == 1, 0, 0, 0, 0, 32'hBAD0_0000 + i);
      chk("t35_addr", imem_addr, 4);
      chk("t35_req", imem_req, 1);
    end
    step(0, 0, 0, 0, 0, 1, 32'h0010_8113);
    chk("t35_ir", IR, 32'h0010_8113);
    chk("t35_old", PC_Old, 4);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("t36_noreq", imem_req, 0);
    // misaligned target, then wraparound
    step(0, 0, 1, 1, 32'h0000_0102, 0, 0);
    chk("t37_pc", PC, 32'h100);
    chk("t37_mis", misalign, 1);
    step(0, 0, 1, 1, 32'hFFFF_FFFC, 1, 0);
    chk("t37_hold", misalign, 1);
    step(0, 0, 1, 0, 0, 0, 0);
    chk("t38_pc", PC, 0);
    // reset during fetch with coincident ack
    step(0, 1, 1, 1, 32'h40, 0, 0);
    step(1, 1, 1, 0, 0, 1, 32'hDEAD_BEEF);
    chk("t39_ir", IR, 32'h13);
    chk("t39_req", imem_req, 0);
    chk("t39_pc", PC, 0);
    chk("t39_mis", misalign, 0);
    for (int i = 0; i < 600; i++)
      step($urandom_range(49) == 0, $urandom_range(2) == 0, $urandom_range(2) == 0,
           $urandom_range(1) == 0, ($urandom_range(3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC),
           $urandom_range(1) == 0, $urandom);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
